// File: rtl/sprite_pkg.sv
// Shared sprite constants, letter order and the stage-1 bundle
// for the on-screen key-letter sprite row.
package sprite_pkg;

  localparam int SPR_W_DEF = 26;
  localparam int SPR_H_DEF = 33;
  localparam int NUM_KEYS  = 12;
  localparam int ADDR_W    = 19;

  localparam logic [3:0] TRANSPARENT_IDX = 4'd0;

  // ROM select order; LTR_NONE is the idle/past-last-key value
  typedef enum logic [3:0] {
    LTR_A    = 4'd0,
    LTR_W    = 4'd1,
    LTR_S    = 4'd2,
    LTR_E    = 4'd3,
    LTR_D    = 4'd4,
    LTR_F    = 4'd5,
    LTR_T    = 4'd6,
    LTR_G    = 4'd7,
    LTR_Y    = 4'd8,
    LTR_H    = 4'd9,
    LTR_U    = 4'd10,
    LTR_J    = 4'd11,
    LTR_NONE = 4'd12
  } letter_e;

  typedef struct packed {
    logic              vld;
    letter_e           sel;
    logic [ADDR_W-1:0] addr;
  } s1_t;

endpackage

// File: rtl/letter_sprite_reader.sv
// Letter sprite reader: walks a row of 12 key sprites in raster
// order and returns the palette index of the pixel under the beam.
// Ports: Clk, Reset (sync, active high), DrawX/DrawY raster
// position, pixel_valid; rom_addr/letter_sel to the external ROM
// mux, rom_data back; pix_hit/pix_idx 2 cycles after DrawX/DrawY.
// Macro LETTER_HILITE_EN adds key_pressed[11:0] and HILITE_IDX,
// recolouring opaque pixels of pressed keys.
module letter_sprite_reader
  import sprite_pkg::*;
#(
  parameter int SPR_W = SPR_W_DEF,
  parameter int SPR_H = SPR_H_DEF,
  parameter int X0    = 40,
  parameter int Y0    = 400,
  parameter int PITCH = 48
`ifdef LETTER_HILITE_EN
  ,
  parameter logic [3:0] HILITE_IDX = 4'hF
`endif
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [9:0]          DrawX,
  input  logic [9:0]          DrawY,
  input  logic                pixel_valid,
`ifdef LETTER_HILITE_EN
  input  logic [NUM_KEYS-1:0] key_pressed,
`endif
  input  logic [3:0]          rom_data,
  output logic [18:0]         rom_addr,
  output logic [3:0]          letter_sel,
  output logic                pix_hit,
  output logic [3:0]          pix_idx
);

  localparam int XW = $clog2(PITCH + 1);

  localparam logic [9:0]        X0_V     = 10'(X0);
  localparam logic [9:0]        Y0_V     = 10'(Y0);
  localparam logic [10:0]       YEND_V   = 11'(Y0 + SPR_H);
  localparam logic [XW-1:0]     XLAST    = XW'(PITCH - 1);
  localparam logic [XW-1:0]     XSPR     = XW'(SPR_W);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(SPR_W);
  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(SPR_W * SPR_H - 1);

  logic [XW-1:0]     xoff_q, xoff_d;
  letter_e           key_q, key_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic              row_ok_q, row_ok_d;
  s1_t               s1_q, s1_d;
  logic              pix_hit_q, pix_hit_d;
  logic [3:0]        pix_idx_q, pix_idx_d;

  logic              at_x0;
  logic              in_band;
  logic [XW-1:0]     xoff_cur;
  letter_e           key_cur;
  logic [ADDR_W-1:0] addr_cur;
  logic              in_region;
  logic              opaque;

  // Counters and stage 1
  always_comb begin
    at_x0      = (DrawX == X0_V);
    in_band    = (DrawY >= Y0_V) && ({1'b0, DrawY} < YEND_V);
    xoff_cur   = at_x0 ? '0 : xoff_q;
    key_cur    = at_x0 ? LTR_A : key_q;
    row_base_d = row_base_q;
    row_ok_d   = row_ok_q;

    // Row base is only trusted after the band's top line has been
    // seen at DrawX==0; a mid-frame reset therefore stays dark
    // until the next frame.
    if (DrawX == '0) begin
      if (DrawY == Y0_V) begin
        row_base_d = '0;
        row_ok_d   = 1'b1;
      end else if (in_band) begin
        row_base_d = row_base_q + ROW_STEP;
      end
    end

    xoff_d = (xoff_cur == XLAST) ? '0 : xoff_cur + XW'(1);
    key_d  = key_cur;
    if (xoff_cur == XLAST && key_cur != LTR_NONE) begin
      key_d = letter_e'(key_cur + 4'd1);
    end

    addr_cur  = row_base_d + ADDR_W'(xoff_cur);
    in_region = pixel_valid && in_band && row_ok_d &&
                (key_cur != LTR_NONE) && (xoff_cur < XSPR) &&
                (addr_cur <= ADDR_MAX);

    s1_d      = '0;
    s1_d.sel  = LTR_A;
    if (in_region) begin
      s1_d.vld  = 1'b1;
      s1_d.sel  = key_cur;
      s1_d.addr = addr_cur;
    end
  end

  // Stage 2: rom_data answers the stage-1 address this cycle
  always_comb begin
    opaque    = s1_q.vld && (rom_data != TRANSPARENT_IDX);
    pix_hit_d = opaque;
    pix_idx_d = opaque ? rom_data : TRANSPARENT_IDX;
`ifdef LETTER_HILITE_EN
    if (opaque && (s1_q.sel != LTR_NONE) &&
        key_pressed[s1_q.sel]) begin
      pix_idx_d = HILITE_IDX;
    end
`endif
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      xoff_q     <= '0;
      key_q      <= LTR_NONE;
      row_base_q <= '0;
      row_ok_q   <= 1'b0;
      s1_q       <= '0;
      pix_hit_q  <= 1'b0;
      pix_idx_q  <= '0;
    end else begin
      xoff_q     <= xoff_d;
      key_q      <= key_d;
      row_base_q <= row_base_d;
      row_ok_q   <= row_ok_d;
      s1_q       <= s1_d;
      pix_hit_q  <= pix_hit_d;
      pix_idx_q  <= pix_idx_d;
    end
  end

  assign rom_addr   = s1_q.addr;
  assign letter_sel = s1_q.sel;
  assign pix_hit    = pix_hit_q;
  assign pix_idx    = pix_idx_q;

endmodule

// File: tb/tb_letter_sprite_reader.sv
// Scoreboard bench for letter_sprite_reader: raster sweep over the
// sprite band, a mid-frame reset, then a clean frame.
module tb_letter_sprite_reader;

  localparam int SPR_W    = 26;
  localparam int SPR_H    = 33;
  localparam int X0       = 40;
  localparam int Y0       = 400;
  localparam int PITCH    = 48;
  localparam int LINE_LEN = 640;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        pixel_valid;
  logic [18:0] rom_addr;
  logic [3:0]  letter_sel;
  logic [3:0]  rom_data;
  logic        pix_hit;
  logic [3:0]  pix_idx;
`ifdef LETTER_HILITE_EN
  logic [11:0] key_pressed = 12'h004;
`endif

  typedef struct packed {
    logic        rst;
    logic        vld;
    logic [18:0] addr;
    logic [3:0]  sel;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  logic frame_ok = 1'b0;

  letter_sprite_reader #(
    .SPR_W(SPR_W),
    .SPR_H(SPR_H),
    .X0(X0),
    .Y0(Y0),
    .PITCH(PITCH)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .DrawX(DrawX),
    .DrawY(DrawY),
    .pixel_valid(pixel_valid),
`ifdef LETTER_HILITE_EN
    .key_pressed(key_pressed),
`endif
    .rom_data(rom_data),
    .rom_addr(rom_addr),
    .letter_sel(letter_sel),
    .pix_hit(pix_hit),
    .pix_idx(pix_idx)
  );

  always #5 Clk = ~Clk;

  function automatic logic [3:0] rom_fn(input logic [3:0] sel,
                                        input logic [18:0] addr);
    logic [18:0] v;
    v = (addr + 19'(sel) * 19'd3) % 19'd7;
    return v[3:0];
  endfunction

  assign rom_data = rom_fn(letter_sel, rom_addr);

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (x=%0d y=%0d t=%0t)",
               tag, got, exp, DrawX, DrawY, $time);
    end
  endtask

  task automatic drive(input int x, input int y, input logic pv,
                       input logic rst);
    exp_t e;
    int   dx, dy, k, xo;
    DrawX       = 10'(x);
    DrawY       = 10'(y);
    pixel_valid = pv;
    Reset       = rst;
    if (rst) frame_ok = 1'b0;
    else if (x == 0 && y == Y0) frame_ok = 1'b1;
    dx     = x - X0;
    dy     = y - Y0;
    e      = '0;
    e.rst  = rst;
    if (!rst && frame_ok && pv && dx >= 0 && dy >= 0 && dy < SPR_H) begin
      k  = dx / PITCH;
      xo = dx % PITCH;
      if (k < 12 && xo < SPR_W) begin
        e.vld  = 1'b1;
        e.addr = 19'(dy * SPR_W + xo);
        e.sel  = 4'(k);
      end
    end
    q.push_back(e);
  endtask

  task automatic step(input int x, input int y, input logic pv,
                      input logic rst);
    exp_t e1, e0;
    logic [3:0] d, idx;
    logic       hit;
    drive(x, y, pv, rst);
    @(posedge Clk);
    #1;
    e1 = q[q.size()-1];
    check("rom_addr", 32'(rom_addr), 32'(e1.addr));
    check("letter_sel", 32'(letter_sel), 32'(e1.sel));
    if (q.size() == 2) begin
      e0  = q.pop_front();
      d   = rom_fn(e0.sel, e0.addr);
      hit = e0.vld && (d != 4'd0) && !e1.rst;
      idx = hit ? d : 4'd0;
`ifdef LETTER_HILITE_EN
      if (hit && key_pressed[e0.sel]) idx = 4'hF;
`endif
      check("pix_hit", 32'(hit ? 1 : 0), 32'(pix_hit));
      check("pix_idx", 32'(pix_idx), 32'(idx));
    end
  endtask

  task automatic run_frame(input int rst_line, input int rst_x);
    logic r, pv;
    for (int y = Y0 - 1; y <= Y0 + SPR_H; y++) begin
      for (int x = 0; x < LINE_LEN; x++) begin
        r  = (y == rst_line) && (x >= rst_x) && (x < rst_x + 4);
        pv = (x < 630) &&
             !(y == Y0 + 3 && x >= X0 + 2 * PITCH &&
               x < X0 + 2 * PITCH + 10);
        step(x, y, pv, r);
      end
    end
  endtask

  initial begin
    DrawX       = '0;
    DrawY       = '0;
    pixel_valid = 1'b0;
    Reset       = 1'b1;
    for (int i = 0; i < 5; i++) step(i, 0, 1'b0, 1'b1);
    run_frame(Y0 + 10, 100);
    run_frame(-1, 0);
    step(0, 0, 1'b0, 1'b0);
    step(1, 0, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
